// File: rtl/ok_wire_in_bank.sv
// Multi-channel Wire In endpoint bank: host words land in staging registers and one
// ti_wireupdate moves all channels to ep_dataout together. Optional macro: WIREIN_CHANGE_EN.
module ok_wire_in_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                     ti_clock,
  input  logic                     ti_reset_n,
  input  logic                     ti_reset,
  input  logic                     ti_write,
  input  logic [7:0]               ti_addr,
  input  logic [15:0]              ti_datain,
  input  logic                     ti_wireupdate,
  output logic [NUM_CH*CH_W-1:0]   ep_dataout,
  output logic [NUM_CH-1:0]        ep_changed,
  output logic [CNT_W-1:0]         ep_update_cnt,
  output logic                     ep_addr_hit
);

  localparam int unsigned WORDS     = (CH_W + 15) / 16;
  localparam int unsigned NUM_WORDS = NUM_CH * WORDS;

  if (32'(BASE_ADDR) + NUM_WORDS - 1 > 32'd255) begin : g_addr_check
    $error("ok_wire_in_bank: address map exceeds 8'hFF");
  end

  logic [NUM_CH-1:0][CH_W-1:0] stage_q;
  logic [NUM_CH-1:0][CH_W-1:0] stage_nxt;
  logic [NUM_CH-1:0][CH_W-1:0] dout_q;
  logic [7:0]                  off;
  logic                        hit;

  // Decode the write and build the post-write staging image (also feeds write-through).
  always_comb begin
    off       = ti_addr - BASE_ADDR;
    hit       = ti_write && (ti_addr >= BASE_ADDR) && (32'(off) < NUM_WORDS);
    stage_nxt = stage_q;
    if (hit) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned b = 0; b < CH_W; b++) begin
          if (32'(off) == c * WORDS + b / 16) begin
            stage_nxt[c][b] = ti_datain[4'(b % 16)];
          end
        end
      end
    end
  end

  always_ff @(posedge ti_clock or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      stage_q       <= '0;
      dout_q        <= '0;
      ep_update_cnt <= '0;
      ep_addr_hit   <= 1'b0;
    end else if (ti_reset) begin
      stage_q       <= '0;
      dout_q        <= '0;
      ep_update_cnt <= '0;
      ep_addr_hit   <= 1'b0;
    end else begin
      stage_q     <= stage_nxt;
      ep_addr_hit <= hit;
      if (ti_wireupdate) begin
        dout_q        <= stage_nxt;
        ep_update_cnt <= ep_update_cnt + CNT_W'(1);
      end
    end
  end

  assign ep_dataout = dout_q;

`ifdef WIREIN_CHANGE_EN
  logic [NUM_CH-1:0] diff;
  logic [NUM_CH-1:0] changed_q;

  always_comb begin
    diff = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      diff[c] = (stage_nxt[c] != dout_q[c]);
    end
  end

  // Reset-driven clears never pulse; each update produces its own pulse.
  always_ff @(posedge ti_clock or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      changed_q <= '0;
    end else if (ti_reset) begin
      changed_q <= '0;
    end else begin
      changed_q <= ti_wireupdate ? diff : '0;
    end
  end

  assign ep_changed = changed_q;
`else
  assign ep_changed = '0;
`endif

endmodule

// File: tb/tb_ok_wire_in_bank.sv
// Directed bench for ok_wire_in_bank: three instances (16-bit, 20-bit, 2-bit counter) share one host bus.
module tb_ok_wire_in_bank;

`ifdef WIREIN_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic        ti_clock = 1'b0;
  logic        ti_reset_n;
  logic        ti_reset;
  logic        ti_write;
  logic [7:0]  ti_addr;
  logic [15:0] ti_datain;
  logic        ti_wireupdate;

  logic [63:0] dout_a;  logic [3:0] chg_a;  logic [7:0] cnt_a;  logic hit_a;
  logic [79:0] dout_b;  logic [3:0] chg_b;  logic [7:0] cnt_b;  logic hit_b;
  logic [63:0] dout_c;  logic [3:0] chg_c;  logic [1:0] cnt_c;  logic hit_c;

  int total = 0;
  int bad   = 0;

  always #5 ti_clock = ~ti_clock;

  ok_wire_in_bank #(.NUM_CH(4), .CH_W(16), .BASE_ADDR(8'h10), .CNT_W(8)) u_a (
    .ti_clock(ti_clock), .ti_reset_n(ti_reset_n), .ti_reset(ti_reset), .ti_write(ti_write),
    .ti_addr(ti_addr), .ti_datain(ti_datain), .ti_wireupdate(ti_wireupdate),
    .ep_dataout(dout_a), .ep_changed(chg_a), .ep_update_cnt(cnt_a), .ep_addr_hit(hit_a));

  ok_wire_in_bank #(.NUM_CH(4), .CH_W(20), .BASE_ADDR(8'h00), .CNT_W(8)) u_b (
    .ti_clock(ti_clock), .ti_reset_n(ti_reset_n), .ti_reset(ti_reset), .ti_write(ti_write),
    .ti_addr(ti_addr), .ti_datain(ti_datain), .ti_wireupdate(ti_wireupdate),
    .ep_dataout(dout_b), .ep_changed(chg_b), .ep_update_cnt(cnt_b), .ep_addr_hit(hit_b));

  ok_wire_in_bank #(.NUM_CH(4), .CH_W(16), .BASE_ADDR(8'h10), .CNT_W(2)) u_c (
    .ti_clock(ti_clock), .ti_reset_n(ti_reset_n), .ti_reset(ti_reset), .ti_write(ti_write),
    .ti_addr(ti_addr), .ti_datain(ti_datain), .ti_wireupdate(ti_wireupdate),
    .ep_dataout(dout_c), .ep_changed(chg_c), .ep_update_cnt(cnt_c), .ep_addr_hit(hit_c));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ce(input logic [3:0] v);
    return CHG_EN ? v : 4'b0000;
  endfunction

  task automatic step();
    @(posedge ti_clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    ti_write = 1'b1; ti_addr = a; ti_datain = d;
    step();
    ti_write = 1'b0;
  endtask

  task automatic upd();
    ti_wireupdate = 1'b1;
    step();
    ti_wireupdate = 1'b0;
  endtask

  initial begin
    ti_reset_n = 1'b0; ti_reset = 1'b0; ti_write = 1'b0;
    ti_addr = 8'h00; ti_datain = 16'h0000; ti_wireupdate = 1'b0;
    #2;
    chk("rst_dout_a", dout_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_hit_a", hit_a, 0);
    chk("rst_chg_a", chg_a, 0);
    chk("rst_dout_b", dout_b, 0);
    #1 ti_reset_n = 1'b1;

    // Staging writes stay invisible until an update
    wr(8'h12, 16'hBEEF);
    chk("hit_a_w12", hit_a, 1);
    chk("hit_b_w12", hit_b, 0);
    chk("dout_a_pre", dout_a, 0);
    wr(8'h02, 16'h1234);
    chk("hit_a_w02", hit_a, 0);
    chk("hit_b_w02", hit_b, 1);
    wr(8'h03, 16'hFFFA);
    chk("dout_b_partial", dout_b, 0);

    upd();
    chk("dout_a_upd1", dout_a, 64'h0000_BEEF_0000_0000);
    chk("chg_a_upd1", chg_a, ce(4'b0100));
    chk("cnt_a_upd1", cnt_a, 1);
    chk("dout_b_upd1", dout_b, 80'hA1234_00000);
    chk("chg_b_upd1", chg_b, ce(4'b0010));
    chk("cnt_b_upd1", cnt_b, 1);
    chk("hit_b_drop", hit_b, 0);
    chk("cnt_c_1", cnt_c, 1);

    step();
    chk("chg_a_idle", chg_a, 0);
    chk("chg_b_idle", chg_b, 0);

    // Same-edge write and update: write-through
    ti_write = 1'b1; ti_addr = 8'h10; ti_datain = 16'h0055; ti_wireupdate = 1'b1;
    step();
    ti_write = 1'b0; ti_wireupdate = 1'b0;
    chk("dout_a_wt", dout_a, 64'h0000_BEEF_0000_0055);
    chk("chg_a_wt", chg_a, ce(4'b0001));
    chk("hit_a_wt", hit_a, 1);
    chk("chg_b_wt", chg_b, 0);
    chk("cnt_c_2", cnt_c, 2);

    upd();
    chk("chg_a_same", chg_a, 0);
    chk("dout_a_same", dout_a, 64'h0000_BEEF_0000_0055);
    chk("cnt_c_3", cnt_c, 3);

    // Out-of-range address for the 0x10 bank (and the 0x00 bank)
    wr(8'h14, 16'h1111);
    chk("hit_a_oor", hit_a, 0);
    chk("hit_c_oor", hit_c, 0);
    chk("hit_b_oor", hit_b, 0);
    upd();
    chk("dout_a_oor", dout_a, 64'h0000_BEEF_0000_0055);
    chk("cnt_c_wrap0", cnt_c, 0);
    chk("cnt_a_4", cnt_a, 4);
    upd();
    chk("cnt_c_wrap1", cnt_c, 1);
    chk("cnt_a_5", cnt_a, 5);

    // Synchronous reset beats a same-edge write and update
    ti_reset = 1'b1; ti_wireupdate = 1'b1; ti_write = 1'b1; ti_addr = 8'h10; ti_datain = 16'h9999;
    step();
    ti_reset = 1'b0; ti_wireupdate = 1'b0; ti_write = 1'b0;
    chk("srst_dout_a", dout_a, 0);
    chk("srst_cnt_a", cnt_a, 0);
    chk("srst_chg_a", chg_a, 0);
    chk("srst_hit_a", hit_a, 0);
    chk("srst_dout_b", dout_b, 0);
    chk("srst_cnt_c", cnt_c, 0);
    upd();
    chk("srst_stage_a", dout_a, 0);
    chk("srst_chg_after", chg_a, 0);
    chk("srst_cnt_after", cnt_a, 1);

    wr(8'h11, 16'h5A5A);
    upd();
    chk("dout_a_ch1", dout_a, 64'h0000_0000_5A5A_0000);
    chk("chg_a_ch1", chg_a, ce(4'b0010));

    // Asynchronous reset mid-write, checked before any clock edge
    ti_write = 1'b1; ti_addr = 8'h12; ti_datain = 16'h1357;
    #2 ti_reset_n = 1'b0;
    #1;
    chk("arst_dout_a", dout_a, 0);
    chk("arst_cnt_a", cnt_a, 0);
    chk("arst_hit_a", hit_a, 0);
    chk("arst_chg_a", chg_a, 0);
    chk("arst_cnt_c", cnt_c, 0);
    #1 ti_reset_n = 1'b1; ti_write = 1'b0;
    upd();
    chk("arst_stage_a", dout_a, 0);
    chk("arst_cnt_after", cnt_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
